key_gen_param: RTL

KEY_GEN_PARAM -- requirements
Module: key_gen_param

---
 rtl/key_gen_pkg.sv | 26 ++
 rtl/key_debounce.sv | 41 ++++
 rtl/key_gen_param.sv | 79 +++++++
 3 files changed

// File: rtl/key_gen_pkg.sv
// Shared definitions for the parameterised AES key generator.
// Mode encodings, LFSR constants and small word helpers.
package key_gen_pkg;

    typedef enum logic [1:0] {
        MODE_FILL  = 2'd0,
        MODE_INDEX = 2'd1,
        MODE_LFSR  = 2'd2,
        MODE_HOLD  = 2'd3
    } mode_t;

    localparam logic [31:0] LFSR_MASK = 32'h8020_0003;
    localparam logic [31:0] LFSR_SEED = 32'hACE1_0001;

    function automatic logic [31:0] lfsr_step(input logic [31:0] v);
        return (v >> 1) ^ (v[0] ? LFSR_MASK : 32'h0);
    endfunction

    // Rotate left by sh mod 32 using a doubled word.
    function automatic logic [31:0] rotl32(input logic [31:0] v, input int sh);
        logic [63:0] d;
        d = {v, v} << sh[4:0];
        return d[63:32];
    endfunction

endpackage

// File: rtl/key_debounce.sv
// Two-flop synchroniser and stability-count debouncer for one button.
// stable follows raw DEB_CYC+2 edges after a change that holds steady.
module key_debounce
    import key_gen_pkg::*;
#(
    parameter int DEB_CYC = 16
) (
    input  logic sclk,
    input  logic rst,
    input  logic raw,
    output logic stable
);

    localparam int CW = (DEB_CYC > 1) ? $clog2(DEB_CYC) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(DEB_CYC - 1);

    logic          sync1;
    logic          sync2;
    logic [CW-1:0] cnt;

    always_ff @(posedge sclk) begin
        if (rst) begin
            sync1  <= 1'b0;
            sync2  <= 1'b0;
            stable <= 1'b0;
            cnt    <= '0;
        end else begin
            sync1 <= raw;
            sync2 <= sync1;
            if (sync2 == stable) begin
                cnt <= '0;
            end else if (cnt == CNT_LAST) begin
                stable <= sync2;
                cnt    <= '0;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/key_gen_param.sv
// Periodic key generator: debounced buttons select words of a pattern
// that is loaded into a valid/ready output register.
module key_gen_param
    import key_gen_pkg::*;
#(
    parameter int KEY_W    = 128,
    parameter int WORDS    = KEY_W / 32,
    parameter int DEB_CYC  = 16,
    parameter int PERIOD_W = 5
) (
    input  logic                sclk,
    input  logic                rst,
    input  logic [WORDS-1:0]    key_bus,
    input  logic [1:0]          mode,
    input  logic [PERIOD_W-1:0] period,
    input  logic                key_ready,
    output logic [KEY_W-1:0]    key_data,
    output logic                key_valid
);

    logic [WORDS-1:0]    deb;
    logic [PERIOD_W-1:0] cnt;
    logic [PERIOD_W-1:0] period_eff;
    logic [31:0]         lfsr;
    logic [KEY_W-1:0]    pattern;
    logic                load;
    logic                take;

    for (genvar gi = 0; gi < WORDS; gi++) begin : gen_deb
        key_debounce #(
            .DEB_CYC(DEB_CYC)
        ) u_deb (
            .sclk  (sclk),
            .rst   (rst),
            .raw   (key_bus[gi]),
            .stable(deb[gi])
        );
    end

    assign period_eff = (period == '0) ? PERIOD_W'(1) : period;
    // >= lets a shortened period fire on the very next edge.
    assign load = !key_valid && (cnt >= period_eff);
    assign take = key_valid && key_ready;

    always_comb begin
        pattern = key_data;
        for (int i = 0; i < WORDS; i++) begin
            unique case (mode_t'(mode))
                MODE_FILL:
                    pattern[32*i +: 32] = deb[i] ? 32'hFFFF_FFFF : 32'h0;
                MODE_INDEX:
                    pattern[32*i +: 32] = deb[i] ? {4{8'(i)}} : 32'h0;
                MODE_LFSR:
                    pattern[32*i +: 32] = deb[i] ? rotl32(lfsr, 8 * i) : 32'h0;
                MODE_HOLD:
                    pattern[32*i +: 32] = key_data[32*i +: 32];
            endcase
        end
    end

    always_ff @(posedge sclk) begin
        if (rst) begin
            key_data  <= '0;
            key_valid <= 1'b0;
            cnt       <= '0;
            lfsr      <= LFSR_SEED;
        end else if (take) begin
            key_valid <= 1'b0;
            lfsr      <= lfsr_step(lfsr);
        end else if (load) begin
            key_valid <= 1'b1;
            key_data  <= pattern;
            cnt       <= '0;
        end else if (!key_valid) begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule
